// File: rtl/pmem_arbiter_if.sv
// Cache-side and memory-side line-port signals of the icache/dcache physical-memory arbiter.
// slave: the arbiter's view; master: the caches and downstream memory driving it.
interface pmem_arbiter_if #(
    parameter int unsigned s_line = 256,
    parameter int unsigned s_addr = 32
);
    logic              i_pmem_read;
    logic [s_addr-1:0] i_pmem_address;
    logic [s_line-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [s_addr-1:0] d_pmem_address;
    logic [s_line-1:0] d_pmem_wdata;
    logic [s_line-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    logic              mem_read;
    logic              mem_write;
    logic [s_addr-1:0] mem_address;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin two-to-one arbiter serialising icache reads and dcache reads/writes onto
// the single physical-memory line port; one IDLE arbitration cycle precedes every transaction.
module pmem_arbiter #(
    parameter int unsigned s_line = 256,
    parameter int unsigned s_addr = 32
) (
    input  logic            clk,
    input  logic            rst,
    pmem_arbiter_if.slave   bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic              last_d_q, last_d_d;
    logic [s_addr-1:0] addr_q,   addr_d;
    logic [s_line-1:0] wdata_q,  wdata_d;
    logic              read_q,   read_d;
    logic              write_q,  write_d;

    logic i_req;
    logic d_req;
    logic d_wins;

    assign i_req  = bus.i_pmem_read;
    assign d_req  = bus.d_pmem_read | bus.d_pmem_write;
    // dcache takes the grant when alone, or on a tie when the icache was served last
    assign d_wins = d_req && (!i_req || !last_d_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            read_q   <= read_d;
            write_q  <= write_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        read_d   = read_q;
        write_d  = write_q;

        case (state_q)
            IDLE: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                if (d_wins) begin
                    state_d = SERVE_D;
                    addr_d  = bus.d_pmem_address;
                    wdata_d = bus.d_pmem_wdata;
                    // simultaneous read+write is resolved as a write
                    write_d = bus.d_pmem_write;
                    read_d  = !bus.d_pmem_write;
                end else if (i_req) begin
                    state_d = SERVE_I;
                    addr_d  = bus.i_pmem_address;
                    read_d  = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) begin
                    state_d  = IDLE;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    last_d_d = (state_q == SERVE_D);
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_read    = read_q;
    assign bus.mem_write   = write_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;

    // completion is forwarded in the same cycle as mem_resp, only to the owner
    assign bus.i_pmem_resp  = (state_q == SERVE_I) && bus.mem_resp;
    assign bus.d_pmem_resp  = (state_q == SERVE_D) && bus.mem_resp;
    assign bus.i_pmem_rdata = bus.mem_rdata;
    assign bus.d_pmem_rdata = bus.mem_rdata;

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Two-to-one arbiter between the instruction cache and the data cache for the single physical-memory line port.
- Accepts 256-bit line read requests from the icache and line read/write requests from the dcache, and serialises them onto one downstream port.
- Routes the response and read data back to the requester that owns the current transaction.
- Round-robin priority prevents either cache from starving the other.

Parameters:
- s_line, 256, line width in bits (matches cache line)
- s_addr, 32, address width in bits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  icache line read request (level, held until i_pmem_resp)
- i_pmem_address  in  s_addr  icache line address
- i_pmem_rdata  out  s_line  line data to icache
- i_pmem_resp  out  1  one-cycle completion pulse to icache
- d_pmem_read  in  1  dcache line read request (level)
- d_pmem_write  in  1  dcache line write request (level)
- d_pmem_address  in  s_addr  dcache line address
- d_pmem_wdata  in  s_line  dcache writeback data
- d_pmem_rdata  out  s_line  line data to dcache
- d_pmem_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  downstream read request
- mem_write  out  1  downstream write request
- mem_address  out  s_addr  downstream address
- mem_wdata  out  s_line  downstream write data
- mem_rdata  in  s_line  downstream read data
- mem_resp  in  1  downstream completion

Behaviour:

States: IDLE, SERVE_I, SERVE_D.

IDLE:
- mem_read = 0 and mem_write = 0.
- If any request is pending, latch the winner's address, data and op into registers and move to SERVE_I or SERVE_D on the next edge.
- No downstream request is issued in the arbitration cycle.
- Winner selection:
  - only one requester active: that requester wins.
  - both active: the requester not served last wins.

SERVE_I:
- mem_read = 1 and mem_address = latched address, held every cycle until mem_resp.

SERVE_D:
- mem_read or mem_write per the latched op.
- mem_address and mem_wdata come from the latched registers, held until mem_resp.

Response handling:
- In a cycle with mem_resp = 1 in SERVE_x, the owner's x_pmem_resp = 1 combinationally in the same cycle.
- x_pmem_rdata = mem_rdata in that cycle.
- Next state is IDLE, and the last-served pointer is updated to x.
- i_pmem_rdata and d_pmem_rdata may always mirror mem_rdata; the resp signals gate validity.
- The non-owner's resp is always 0.

Latency:
- Request sampled in IDLE at cycle 0; downstream request asserted from cycle 1.
- Owner resp arrives in the same cycle as mem_resp.
- Minimum round trip is 2 cycles. There is one IDLE bubble between back-to-back transactions.

Requester contract:
- A request is deasserted in the cycle after its resp, unless it is a new transaction.
- Address and data are stable while a request is held. The arbiter latches them anyway, so the downstream port never glitches.

Corner cases:
- d_pmem_read and d_pmem_write both high: illegal; the arbiter treats it as a write, and the bench asserts it never occurs.
- mem_resp while in IDLE: ignored, no resp issued.
- A request that drops while its transaction is in flight: the transaction still completes on the downstream port and the resp is still pulsed. No abort.
- A new request arriving during SERVE for the other cache: held pending, and served next per round-robin.

Reset (rst = 1 at a clock edge):
- state = IDLE and last-served = dcache, so the icache wins the first tie.
- Latched registers are cleared to 0.
- Outputs then: mem_read = 0, mem_write = 0, mem_address = 0, mem_wdata = 0, i_pmem_resp = 0, d_pmem_resp = 0.
- Reset mid-transaction abandons it; no resp is issued. The downstream memory is reset on the same rst.

Test Plan:
- Lone icache read, address 0x0000_0060, memory resp after 3 cycles with data pattern A -> mem_read high cycles 1-4 with mem_address 0x60, i_pmem_resp single pulse with rdata A, d_pmem_resp stays 0.
- Lone dcache write, address 0x0000_1000, wdata B -> mem_write high, mem_address 0x1000, mem_wdata B until mem_resp, d_pmem_resp pulse; mem_read never high.
- Simultaneous i read 0x100 and d read 0x200 right after reset -> icache served first (0x100), one IDLE cycle, then 0x200. Repeat the tie -> dcache served first (alternation).
- Continuous icache requests with a dcache request pending -> dcache served no later than the second downstream transaction; no starvation over 20 iterations.
- rst asserted mid-SERVE_D with mem_write high -> next cycle mem_write = 0, state IDLE, no d_pmem_resp. A later icache request completes normally.
- Spurious mem_resp in IDLE -> no resp to either cache, state unchanged.
